// File: rtl/ps2_pkg.sv
// ============================================================================
// Module      : ps2_pkg
// Description : Shared types and scan-code constants for the PS/2 key
//               sequencer and its modifier tracker.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package ps2_pkg;

    typedef enum logic [1:0] {
        ST_WAIT   = 2'd0,
        ST_POP    = 2'd1,
        ST_GAP    = 2'd2,
        ST_DECODE = 2'd3
    } state_e;

    localparam logic [7:0] SC_EXT    = 8'hE0;
    localparam logic [7:0] SC_BRK    = 8'hF0;
    localparam logic [7:0] SC_LSHIFT = 8'h12;
    localparam logic [7:0] SC_RSHIFT = 8'h59;
    localparam logic [7:0] SC_CTRL   = 8'h14;
    localparam logic [7:0] SC_CAPS   = 8'h58;

    // Keyboard status/acknowledge bytes that carry no key information.
    localparam int N_IGNORE = 4;
    localparam logic [N_IGNORE-1:0][7:0] IGNORE_LIST = {8'hAA, 8'hFA, 8'hEE, 8'hFE};

    function automatic logic is_ignored(input logic [7:0] b);
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < N_IGNORE; i++) begin
            if (b == IGNORE_LIST[i]) hit = 1'b1;
        end
        return hit;
    endfunction

endpackage

`default_nettype wire

// File: rtl/ps2_mod_tracker.sv
// ============================================================================
// Module      : ps2_mod_tracker
// Description : Held-key / typematic-repeat detection, modifier flags, caps
//               toggle and fresh-press counter. Macro: TYPEMATIC_FILTER_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ps2_mod_tracker
    import ps2_pkg::*;
#(
    parameter int COUNT_W = 8
) (
    input  logic               clk,
    input  logic               clrn,
    input  logic               ev_valid_i,
    input  logic [7:0]         ev_code_i,
    input  logic               ev_ext_i,
    input  logic               ev_make_i,
    output logic               repeat_o,
    output logic               shift_on_o,
    output logic               ctrl_on_o,
    output logic               caps_on_o,
    output logic [COUNT_W-1:0] key_count_o
);

    logic [7:0]         held_code_q, held_code_d;
    logic               held_ext_q,  held_ext_d;
    logic               held_v_q,    held_v_d;
    logic               lshift_q,    lshift_d;
    logic               rshift_q,    rshift_d;
    logic               ctrl_n_q,    ctrl_n_d;
    logic               ctrl_e_q,    ctrl_e_d;
    logic               caps_q,      caps_d;
    logic [COUNT_W-1:0] count_q,     count_d;

    logic w_match;
    logic w_repeat;
    logic w_fresh;
    logic w_mod_upd;

    assign w_match  = held_v_q && (held_code_q == ev_code_i) && (held_ext_q == ev_ext_i);
    assign w_repeat = ev_valid_i && ev_make_i && w_match;
    assign w_fresh  = ev_valid_i && ev_make_i && !w_match;

`ifdef TYPEMATIC_FILTER_EN
    assign w_mod_upd = ev_valid_i && !w_repeat;
`else
    assign w_mod_upd = ev_valid_i;
`endif

    always_comb begin
        held_code_d = held_code_q;
        held_ext_d  = held_ext_q;
        held_v_d    = held_v_q;
        lshift_d    = lshift_q;
        rshift_d    = rshift_q;
        ctrl_n_d    = ctrl_n_q;
        ctrl_e_d    = ctrl_e_q;
        caps_d      = caps_q;
        count_d     = count_q;

        // A break of some other key leaves the held register alone.
        if (w_fresh) begin
            held_code_d = ev_code_i;
            held_ext_d  = ev_ext_i;
            held_v_d    = 1'b1;
            count_d     = count_q + {{(COUNT_W-1){1'b0}}, 1'b1};
        end else if (ev_valid_i && !ev_make_i && w_match) begin
            held_v_d    = 1'b0;
        end

        if (w_mod_upd) begin
            if (ev_code_i == SC_LSHIFT) lshift_d = ev_make_i;
            if (ev_code_i == SC_RSHIFT) rshift_d = ev_make_i;
            if (ev_code_i == SC_CTRL) begin
                if (ev_ext_i) ctrl_e_d = ev_make_i;
                else          ctrl_n_d = ev_make_i;
            end
        end

        if (w_fresh && (ev_code_i == SC_CAPS)) caps_d = ~caps_q;
    end

    always_ff @(posedge clk) begin
        if (!clrn) begin
            held_code_q <= 8'h00;
            held_ext_q  <= 1'b0;
            held_v_q    <= 1'b0;
            lshift_q    <= 1'b0;
            rshift_q    <= 1'b0;
            ctrl_n_q    <= 1'b0;
            ctrl_e_q    <= 1'b0;
            caps_q      <= 1'b0;
            count_q     <= '0;
        end else begin
            held_code_q <= held_code_d;
            held_ext_q  <= held_ext_d;
            held_v_q    <= held_v_d;
            lshift_q    <= lshift_d;
            rshift_q    <= rshift_d;
            ctrl_n_q    <= ctrl_n_d;
            ctrl_e_q    <= ctrl_e_d;
            caps_q      <= caps_d;
            count_q     <= count_d;
        end
    end

    assign repeat_o    = w_repeat;
    assign shift_on_o  = lshift_q | rshift_q;
    assign ctrl_on_o   = ctrl_n_q | ctrl_e_q;
    assign caps_on_o   = caps_q;
    assign key_count_o = count_q;

endmodule

`default_nettype wire

// File: rtl/ps2_key_sequencer.sv
// ============================================================================
// Module      : ps2_key_sequencer
// Description : Pops the PS/2 receiver FIFO and turns E0/F0 prefix sequences
//               into single key events. Macro: TYPEMATIC_FILTER_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ps2_key_sequencer
    import ps2_pkg::*;
#(
    parameter int COUNT_W        = 8,
    parameter int PREFIX_TIMEOUT = 50000
) (
    input  logic               clk,
    input  logic               clrn,
    input  logic [7:0]         kb_data,
    input  logic               kb_ready,
    input  logic               kb_overflow,
    output logic               kb_nextdata_n,
    output logic               key_valid,
    output logic [7:0]         key_code,
    output logic               key_ext,
    output logic               key_make,
    output logic               key_repeat,
    output logic               shift_on,
    output logic               ctrl_on,
    output logic               caps_on,
    output logic [COUNT_W-1:0] key_count,
    output logic               err_timeout,
    output logic               err_overflow
);

    localparam int              TO_W      = $clog2(PREFIX_TIMEOUT + 1);
    localparam logic [TO_W-1:0] c_TO_LAST = TO_W'(PREFIX_TIMEOUT - 1);

    state_e          state_q,  state_d;
    logic [7:0]      byte_q,   byte_d;
    logic            ext_q,    ext_d;
    logic            brk_q,    brk_d;
    logic [TO_W-1:0] to_cnt_q, to_cnt_d;
    logic            ovf_q;

    logic w_pending;
    logic w_timeout;
    logic w_final;
    logic w_repeat;
    logic w_emit;

    assign w_pending = ext_q | brk_q;
    assign w_timeout = (state_q == ST_WAIT) && w_pending && (to_cnt_q == c_TO_LAST);
    assign w_final   = (state_q == ST_DECODE) && (byte_q != SC_EXT) && (byte_q != SC_BRK)
                       && !is_ignored(byte_q);

    always_comb begin
        state_d  = state_q;
        byte_d   = byte_q;
        ext_d    = ext_q;
        brk_d    = brk_q;
        to_cnt_d = to_cnt_q;

        case (state_q)
            ST_WAIT: begin
                // An abandoned prefix is dropped first, so a byte arriving in
                // the same cycle is popped afterwards with clean flags.
                if (w_timeout) begin
                    ext_d    = 1'b0;
                    brk_d    = 1'b0;
                    to_cnt_d = '0;
                end else if (w_pending) begin
                    to_cnt_d = to_cnt_q + {{(TO_W-1){1'b0}}, 1'b1};
                end
                if (kb_ready) state_d = ST_POP;
            end
            ST_POP: begin
                byte_d   = kb_data;
                to_cnt_d = '0;
                state_d  = ST_GAP;
            end
            ST_GAP: begin
                state_d = ST_DECODE;
            end
            ST_DECODE: begin
                if (byte_q == SC_EXT) begin
                    ext_d = 1'b1;
                end else if (byte_q == SC_BRK) begin
                    brk_d = 1'b1;
                end else if (w_final) begin
                    ext_d = 1'b0;
                    brk_d = 1'b0;
                end
                state_d = ST_WAIT;
            end
            default: begin
                state_d = ST_WAIT;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!clrn) begin
            state_q  <= ST_WAIT;
            byte_q   <= 8'h00;
            ext_q    <= 1'b0;
            brk_q    <= 1'b0;
            to_cnt_q <= '0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            byte_q   <= byte_d;
            ext_q    <= ext_d;
            brk_q    <= brk_d;
            to_cnt_q <= to_cnt_d;
            ovf_q    <= kb_overflow;
        end
    end

    ps2_mod_tracker #(
        .COUNT_W (COUNT_W)
    ) u_mod_tracker (
        .clk         (clk),
        .clrn        (clrn),
        .ev_valid_i  (w_final),
        .ev_code_i   (byte_q),
        .ev_ext_i    (ext_q),
        .ev_make_i   (~brk_q),
        .repeat_o    (w_repeat),
        .shift_on_o  (shift_on),
        .ctrl_on_o   (ctrl_on),
        .caps_on_o   (caps_on),
        .key_count_o (key_count)
    );

`ifdef TYPEMATIC_FILTER_EN
    assign w_emit = clrn && w_final && !w_repeat;
`else
    assign w_emit = clrn && w_final;
`endif

    // Combinational strobes are masked while clrn is low so that nothing
    // escapes during the reset cycle.
    assign kb_nextdata_n = ~((state_q == ST_POP) && clrn);
    assign key_valid     = w_emit;
    assign key_code      = w_emit ? byte_q : 8'h00;
    assign key_ext       = w_emit & ext_q;
    assign key_make      = w_emit & ~brk_q;
    assign key_repeat    = w_emit & w_repeat;
    assign err_timeout   = clrn & w_timeout;
    assign err_overflow  = ovf_q;

endmodule

`default_nettype wire
